if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Holds the PC and drives the instruction-memory address. Computes PC+4.
- Selects the next PC from sequential, branch, jump and jump-register targets returned by decode.
- Registers the fetched instruction and NextPC into the IF/ID latch, with stall-hold and flush-to-NOP.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0000, instruction word inserted into IF/ID on flush and reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
Instruction_if  input  32  instruction word from instruction memory at PC_if (combinational read)
PC_IFWrite  input  1  from decode hazard unit; 0 = hold PC and IF/ID
Z  input  1  from decode; conditional branch in ID is taken
J  input  1  from decode; J/JAL in ID
JR  input  1  from decode; JR/JALR in ID
BranchAddr  input  32  branch target from decode
JumpAddr  input  32  jump target from decode
JrAddr  input  32  register target from decode
PC_if  output  32  current fetch address to instruction memory
Instruction_id  output  32  registered instruction to decode
NextPC_id  output  32  registered PC+4 of the instruction in ID
AddrErr  output  1  sticky flag: a JrAddr with nonzero bits [1:0] was taken

Behaviour:
- One clock; reset is asynchronous and active-low. Names are clk and rst_n.
- Reset (rst_n=0, asynchronous), held while low:
  - PC_if=RESET_PC, Instruction_id=NOP_INST, NextPC_id=32'h0, AddrErr=0.
- First fetch is at RESET_PC on the first rising edge after deassertion.
- NextPC_if = PC_if + 32'd4. 32-bit add; carry dropped, so 32'hFFFF_FFFC wraps to 0.
- Redirect = PC_IFWrite & (JR | J | Z).
- Target priority when several are asserted: JR > J > Z. Low two bits of every target are forced to 2'b00.
- Per rising edge, when PC_IFWrite=0 (stall):
  - PC, Instruction_id, NextPC_id and AddrErr all hold.
  - Z/J/JR are ignored; decode re-presents them next cycle.
- Per rising edge, when PC_IFWrite=1 and no redirect:
  - PC <= NextPC_if, Instruction_id <= Instruction_if, NextPC_id <= NextPC_if.
- Per rising edge, when PC_IFWrite=1 and redirect:
  - PC <= selected target.
  - IF/ID handling per the optional feature (flush or delay slot).
  - If JR is selected and JrAddr[1:0]!=0, AddrErr <= 1.
- Latency:
  - Redirect seen in cycle n gives PC_if=target in cycle n+1.
  - The target instruction reaches Instruction_id in cycle n+2.
- AddrErr is cleared only by reset.
- Reset asserted mid-stall or mid-redirect overrides everything immediately; no pending redirect survives reset.
- No combinational path from Z/J/JR/target inputs to any output; all outputs are registered.

Optional Feature:
BRANCH_DELAY_SLOT_EN
- Defined (MIPS delay slot): on redirect, IF/ID loads Instruction_if/NextPC_if normally, so the slot instruction executes.
- Undefined (default): on redirect, Instruction_id <= NOP_INST and NextPC_id <= 32'h0. The wrong-path fetch is squashed; one bubble per taken control transfer.

Test Plan:
- Reset release, PC_IFWrite=1, no redirects, IMEM returns 32'h1000+PC -> PC_if 0,4,8; Instruction_id 32'h0 then 32'h1000, 32'h1004; NextPC_id 4, 8.
- Stall: PC_IFWrite=0 for 3 cycles with PC_if=8 -> PC_if stays 8, IF/ID unchanged; fetch resumes at 12 on release.
- Z=1, BranchAddr=32'h40 with PC_if=8 (default build) -> next PC_if=32'h40, Instruction_id=NOP; with BRANCH_DELAY_SLOT_EN, Instruction_id=IMEM[8], NextPC_id=12.
- J=1 and Z=1 together, JumpAddr=32'h200, BranchAddr=32'h40 -> PC_if=32'h200. Then JR=1, JrAddr=32'h103 -> PC_if=32'h100, AddrErr=1 and stays 1.
- Z=1 with PC_IFWrite=0 -> no redirect, PC holds. Next cycle Z=1, PC_IFWrite=1 -> redirect taken.
- rst_n pulsed low mid-cycle during redirect -> outputs reset immediately (PC_if=RESET_PC, AddrErr=0). PC_if=32'hFFFF_FFFC sequential -> wraps to 0.

Source files
------------

// File: rtl/if_stage.sv
// ============================================================================
// if_stage : instruction fetch stage with IF/ID pipeline register.
//            Optional macro BRANCH_DELAY_SLOT_EN keeps the slot instruction.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instruction_if,
  input  logic        PC_IFWrite,
  input  logic        Z,
  input  logic        J,
  input  logic        JR,
  input  logic [31:0] BranchAddr,
  input  logic [31:0] JumpAddr,
  input  logic [31:0] JrAddr,
  output logic [31:0] PC_if,
  output logic [31:0] Instruction_id,
  output logic [31:0] NextPC_id,
  output logic        AddrErr
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_q,   pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] npc_q,  npc_d;
  logic        err_q,  err_d;

  logic [31:0] next_pc_if;
  logic        redirect;
  logic [31:0] target;

  assign next_pc_if = pc_q + 32'd4;
  assign redirect   = PC_IFWrite & (JR | J | Z);

  // JR outranks J, which outranks the conditional branch.
  always_comb begin
    target = BranchAddr & ALIGN_MASK;
    if (JR) begin
      target = JrAddr & ALIGN_MASK;
    end else if (J) begin
      target = JumpAddr & ALIGN_MASK;
    end
  end

  always_comb begin
    pc_d   = pc_q;
    inst_d = inst_q;
    npc_d  = npc_q;
    err_d  = err_q;
    if (PC_IFWrite) begin
      if (redirect) begin
        pc_d = target;
`ifdef BRANCH_DELAY_SLOT_EN
        inst_d = Instruction_if;
        npc_d  = next_pc_if;
`else
        inst_d = NOP_INST;
        npc_d  = 32'h0;
`endif
        if (JR && (JrAddr[1:0] != 2'b00)) begin
          err_d = 1'b1;
        end
      end else begin
        pc_d   = next_pc_if;
        inst_d = Instruction_if;
        npc_d  = next_pc_if;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      inst_q <= NOP_INST;
      npc_q  <= 32'h0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
      npc_q  <= npc_d;
      err_q  <= err_d;
    end
  end

  assign PC_if          = pc_q;
  assign Instruction_id = inst_q;
  assign NextPC_id      = npc_q;
  assign AddrErr        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed literal checks plus randomized run against a behavioural model.
`default_nettype none

module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] Instruction_if;
  logic        PC_IFWrite, Z, J, JR;
  logic [31:0] BranchAddr, JumpAddr, JrAddr;
  logic [31:0] PC_if, Instruction_id, NextPC_id;
  logic        AddrErr;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h1000 + a;
  endfunction

  assign Instruction_if = imem(PC_if);

  if_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .Instruction_if(Instruction_if),
    .PC_IFWrite(PC_IFWrite), .Z(Z), .J(J), .JR(JR),
    .BranchAddr(BranchAddr), .JumpAddr(JumpAddr), .JrAddr(JrAddr),
    .PC_if(PC_if), .Instruction_id(Instruction_id),
    .NextPC_id(NextPC_id), .AddrErr(AddrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural PC plus the IF/ID contents.
  logic [31:0] m_pc, m_inst, m_npc, m_seq, m_tgt;
  logic        m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = RST_PC; m_inst = NOP; m_npc = 32'h0; m_err = 1'b0;
    end else if (PC_IFWrite) begin
      m_seq = m_pc + 32'd4;
      if (JR || J || Z) begin
        if (JR) begin
          m_tgt = {JrAddr[31:2], 2'b00};
          if (JrAddr[1:0] != 2'b00) m_err = 1'b1;
        end else if (J) m_tgt = {JumpAddr[31:2], 2'b00};
        else            m_tgt = {BranchAddr[31:2], 2'b00};
`ifdef BRANCH_DELAY_SLOT_EN
        m_inst = imem(m_pc); m_npc = m_seq;
`else
        m_inst = NOP; m_npc = 32'h0;
`endif
        m_pc = m_tgt;
      end else begin
        m_inst = imem(m_pc); m_npc = m_seq; m_pc = m_seq;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model PC_if", PC_if, m_pc);
      check("model Instruction_id", Instruction_id, m_inst);
      check("model NextPC_id", NextPC_id, m_npc);
      check("model AddrErr", {31'h0, AddrErr}, {31'h0, m_err});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; PC_IFWrite = 1'b1; Z = 1'b0; J = 1'b0; JR = 1'b0;
    BranchAddr = 32'h0; JumpAddr = 32'h0; JrAddr = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset PC_if", PC_if, 32'h0);
    check("reset Instruction_id", Instruction_id, 32'h0);
    check("reset NextPC_id", NextPC_id, 32'h0);
    check("reset AddrErr", {31'h0, AddrErr}, 32'h0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    tick();
    check("seq1 PC_if", PC_if, 32'h4);
    check("seq1 Instruction_id", Instruction_id, 32'h1000);
    check("seq1 NextPC_id", NextPC_id, 32'h4);
    tick();
    check("seq2 PC_if", PC_if, 32'h8);
    check("seq2 Instruction_id", Instruction_id, 32'h1004);
    check("seq2 NextPC_id", NextPC_id, 32'h8);

    PC_IFWrite = 1'b0;
    repeat (3) begin
      tick();
      check("stall PC_if", PC_if, 32'h8);
      check("stall Instruction_id", Instruction_id, 32'h1004);
    end
    PC_IFWrite = 1'b1;
    tick();
    check("resume PC_if", PC_if, 32'hC);
    check("resume Instruction_id", Instruction_id, 32'h1008);

    Z = 1'b1; BranchAddr = 32'h43;
    tick();
    check("branch PC_if", PC_if, 32'h40);
`ifdef BRANCH_DELAY_SLOT_EN
    check("branch slot Instruction_id", Instruction_id, 32'h100C);
    check("branch slot NextPC_id", NextPC_id, 32'h10);
`else
    check("branch flush Instruction_id", Instruction_id, 32'h0);
    check("branch flush NextPC_id", NextPC_id, 32'h0);
`endif

    J = 1'b1; JumpAddr = 32'h200;
    tick();
    check("J over Z PC_if", PC_if, 32'h200);
    Z = 1'b0; J = 1'b0; JR = 1'b1; JrAddr = 32'h103;
    tick();
    check("JR PC_if", PC_if, 32'h100);
    check("JR AddrErr", {31'h0, AddrErr}, 32'h1);
    JR = 1'b0;
    tick();
    check("after JR PC_if", PC_if, 32'h104);
    check("sticky AddrErr", {31'h0, AddrErr}, 32'h1);

    PC_IFWrite = 1'b0; Z = 1'b1; BranchAddr = 32'h80;
    tick();
    check("Z during stall PC_if", PC_if, 32'h104);
    PC_IFWrite = 1'b1;
    tick();
    check("Z after stall PC_if", PC_if, 32'h80);

    #1 rst_n = 1'b0;
    #1;
    check("async reset PC_if", PC_if, RST_PC);
    check("async reset AddrErr", {31'h0, AddrErr}, 32'h0);
    check("async reset Instruction_id", Instruction_id, NOP);
    #1 rst_n = 1'b1; Z = 1'b0;
    tick();
    check("post reset PC_if", PC_if, 32'h4);

    J = 1'b1; JumpAddr = 32'hFFFF_FFFC;
    tick();
    check("top PC_if", PC_if, 32'hFFFF_FFFC);
    J = 1'b0;
    tick();
    check("wrap PC_if", PC_if, 32'h0);
    check("wrap NextPC_id", NextPC_id, 32'h0);
    check("wrap Instruction_id", Instruction_id, 32'h0000_0FFC);

    for (int i = 0; i < 3000; i++) begin
      tick();
      PC_IFWrite = ($urandom_range(0, 3) != 0);
      Z  = ($urandom_range(0, 5) == 0);
      J  = ($urandom_range(0, 7) == 0);
      JR = ($urandom_range(0, 7) == 0);
      BranchAddr = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 1023);
      JumpAddr   = ($urandom_range(0, 1) != 0) ? $urandom : 32'hFFFF_FFF0 | $urandom_range(0, 15);
      JrAddr     = $urandom;
      if ($urandom_range(0, 149) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    PC_IFWrite = 1'b1; Z = 1'b0; J = 1'b0; JR = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
